row_accumulator: RTL and testbench

ROW_ACCUMULATOR -- requirements
Module: row_accumulator

---
 rtl/row_accumulator.sv | 124 ++++++++++++
 tb/tb_row_accumulator.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/row_accumulator.sv
// Sparse-row accumulator: pops a row length from the row FIFO, sums that many
// signed products, then presents the row sum with its row index.
// Optional build macro ROW_ACC_SATURATE_EN clamps each addition to the signed range.
module row_accumulator #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int ROW_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    input  logic                  prod_valid,
    input  logic [DATA_WIDTH-1:0] prod_data,
    output logic                  prod_ready,
    output logic                  y_valid,
    output logic [DATA_WIDTH-1:0] y_data,
    output logic [ROW_WIDTH-1:0]  y_row,
    input  logic                  y_ready,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_t;

    state_t                state_reg, state_next;
    logic [DATA_WIDTH-1:0] sum_reg, sum_next;
    logic [LEN_WIDTH-1:0]  remaining_reg, remaining_next;
    logic [ROW_WIDTH-1:0]  row_reg, row_next;
    logic [DATA_WIDTH-1:0] add_result;
    logic [LEN_WIDTH-1:0]  fifo_len;

    assign fifo_len = fifo_data[LEN_WIDTH-1:0];

`ifdef ROW_ACC_SATURATE_EN
    localparam logic [DATA_WIDTH-1:0] SUM_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SUM_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [DATA_WIDTH:0] wide_sum;

    // One extra sign bit exposes overflow: the top two bits differ only when
    // the true result left the signed range.
    always_comb begin
        wide_sum   = {sum_reg[DATA_WIDTH-1], sum_reg} + {prod_data[DATA_WIDTH-1], prod_data};
        add_result = wide_sum[DATA_WIDTH-1:0];
        if (wide_sum[DATA_WIDTH] != wide_sum[DATA_WIDTH-1]) begin
            add_result = wide_sum[DATA_WIDTH] ? SUM_MIN : SUM_MAX;
        end
    end
`else
    assign add_result = sum_reg + prod_data;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            sum_reg       <= '0;
            remaining_reg <= '0;
            row_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            sum_reg       <= sum_next;
            remaining_reg <= remaining_next;
            row_reg       <= row_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        sum_next       = sum_reg;
        remaining_next = remaining_reg;
        row_next       = row_reg;
        fifo_rd_en     = 1'b0;
        prod_ready     = 1'b0;
        y_valid        = 1'b0;

        case (state_reg)
            IDLE: begin
                fifo_rd_en = !fifo_empty;
                if (!fifo_empty) begin
                    remaining_next = fifo_len;
                    sum_next       = '0;
                    state_next     = (fifo_len == '0) ? EMIT : ACCUM;
                end
            end
            ACCUM: begin
                prod_ready = 1'b1;
                if (prod_valid) begin
                    sum_next       = add_result;
                    remaining_next = remaining_reg - LEN_WIDTH'(1);
                    if (remaining_reg == LEN_WIDTH'(1)) begin
                        state_next = EMIT;
                    end
                end
            end
            EMIT: begin
                y_valid = 1'b1;
                if (y_ready) begin
                    row_next   = row_reg + ROW_WIDTH'(1);
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A reset cycle must not look like a pop, a transfer or a result.
        if (reset) begin
            fifo_rd_en = 1'b0;
            prod_ready = 1'b0;
            y_valid    = 1'b0;
        end
    end

    assign y_data = sum_reg;
    assign y_row  = row_reg;
    assign busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_row_accumulator.sv
// Directed bench for row_accumulator: FIFO model, product feeder and a result
// scoreboard compared on every output handshake.
module tb_row_accumulator;

    localparam int DW = 32;
    localparam int LW = 16;
    localparam int RW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data;
    logic          fifo_rd_en;
    logic          prod_valid = 1'b0;
    logic [DW-1:0] prod_data = '0;
    logic          prod_ready;
    logic          y_valid;
    logic [DW-1:0] y_data;
    logic [RW-1:0] y_row;
    logic          y_ready = 1'b1;
    logic          busy;

    typedef struct {
        logic [DW-1:0] data;
        logic [RW-1:0] row;
    } result_t;

    result_t       sb_q[$];
    logic [DW-1:0] fifo_q[$];
    int            passed = 0;
    int            total = 0;
    logic [RW-1:0] exp_row = '0;

    row_accumulator #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .ROW_WIDTH(RW)) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .prod_valid (prod_valid),
        .prod_data  (prod_data),
        .prod_ready (prod_ready),
        .y_valid    (y_valid),
        .y_data     (y_data),
        .y_row      (y_row),
        .y_ready    (y_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic void fifo_update();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? '0 : fifo_q[0];
    endfunction

    initial fifo_update();

    // Pops land 1 time unit after the edge, stimulus changes 2 units after it.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            #1;
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            fifo_update();
        end
    end

    always @(negedge clk) begin
        if (y_valid && y_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_result", 64'(y_data), 64'hDEAD);
            end else begin
                result_t r;
                r = sb_q.pop_front();
                check("sb_y_data", 64'(y_data), 64'(r.data));
                check("sb_y_row", 64'(y_row), 64'(r.row));
                $display("result: row=%0d data=%0h (expected row=%0d data=%0h)", y_row, y_data, r.row, r.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_row(input int len, input logic [DW-1:0] exp_sum);
        result_t r;
        fifo_q.push_back(DW'(len));
        fifo_update();
        r.data = exp_sum;
        r.row  = exp_row;
        sb_q.push_back(r);
        exp_row = exp_row + RW'(1);
    endtask

    task automatic feed(input logic [DW-1:0] v);
        int n = 0;
        while (!prod_ready && n < 20) begin
            step();
            n++;
        end
        if (!prod_ready) check("prod_ready_timeout", 64'(prod_ready), 64'd1);
        prod_valid = 1'b1;
        prod_data  = v;
        step();
        prod_valid = 1'b0;
        $display("product: %0h", v);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || !fifo_empty) && n < 50) begin
            step();
            n++;
        end
        check("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        exp_row = '0;
    endtask

    initial begin
        do_reset();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_y_valid", 64'(y_valid), 64'd0);
        check("rst_y_row", 64'(y_row), 64'd0);
        check("rst_prod_ready", 64'(prod_ready), 64'd0);
        check("rst_fifo_rd_en", 64'(fifo_rd_en), 64'd0);

        // Row of three products.
        push_row(3, DW'(13));
        feed(DW'(5));
        feed(-DW'(2));
        feed(DW'(10));
        check("s1_y_valid", 64'(y_valid), 64'd1);
        check("s1_y_data", 64'(y_data), 64'd13);
        check("s1_y_row", 64'(y_row), 64'd0);
        step();
        check("s1_y_valid_one_cycle", 64'(y_valid), 64'd0);
        wait_idle();

        // Zero-length row followed by a two-product row.
        do_reset();
        push_row(0, DW'(0));
        push_row(2, DW'(14));
        step();
        check("s2_zero_emit", 64'(y_valid), 64'd1);
        check("s2_zero_prod_ready", 64'(prod_ready), 64'd0);
        check("s2_zero_y_data", 64'(y_data), 64'd0);
        feed(DW'(7));
        feed(DW'(7));
        check("s2_y_data", 64'(y_data), 64'd14);
        check("s2_y_row", 64'(y_row), 64'd1);
        wait_idle();

        // Stall in ACCUM.
        push_row(2, DW'(10));
        feed(DW'(4));
        for (int i = 0; i < 5; i++) begin
            step();
            check("s3_gap_sum", 64'(y_data), 64'd4);
            check("s3_gap_ready", 64'(prod_ready), 64'd1);
        end
        feed(DW'(6));
        check("s3_y_data", 64'(y_data), 64'd10);
        wait_idle();

        // Back-pressure in EMIT with a waiting row in the FIFO.
        y_ready = 1'b0;
        push_row(1, DW'(3));
        feed(DW'(3));
        push_row(1, DW'(11));
        for (int i = 0; i < 4; i++) begin
            check("s4_hold_valid", 64'(y_valid), 64'd1);
            check("s4_hold_data", 64'(y_data), 64'd3);
            check("s4_hold_row", 64'(y_row), 64'(exp_row - RW'(2)));
            check("s4_hold_no_pop", 64'(fifo_rd_en), 64'd0);
            step();
        end
        y_ready = 1'b1;
        #1;
        check("s4_handshake_no_pop", 64'(fifo_rd_en), 64'd0);
        step();
        check("s4_after_valid", 64'(y_valid), 64'd0);
        check("s4_after_pop", 64'(fifo_rd_en), 64'd1);
        feed(DW'(11));
        wait_idle();

        // Overflow on the signed boundary.
`ifdef ROW_ACC_SATURATE_EN
        push_row(2, 32'h7FFF_FFFF);
`else
        push_row(2, 32'h8000_0000);
`endif
        feed(32'h7FFF_FFFF);
        feed(32'h0000_0001);
        wait_idle();

        // Reset in the middle of a row; its partial sum is discarded.
        fifo_q.push_back(DW'(4));
        fifo_update();
        feed(DW'(1));
        feed(DW'(2));
        reset = 1'b1;
        prod_valid = 1'b1;
        prod_data = DW'(100);
        #1;
        check("s6_rst_no_valid", 64'(y_valid), 64'd0);
        check("s6_rst_no_pop", 64'(fifo_rd_en), 64'd0);
        step();
        reset = 1'b0;
        prod_valid = 1'b0;
        exp_row = '0;
        #1;
        check("s6_busy", 64'(busy), 64'd0);
        check("s6_y_valid", 64'(y_valid), 64'd0);
        check("s6_y_row", 64'(y_row), 64'd0);
        push_row(1, DW'(9));
        feed(DW'(9));
        check("s6_y_data", 64'(y_data), 64'd9);
        check("s6_y_row_after", 64'(y_row), 64'd0);
        wait_idle();

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
